// File: rtl/regfile_pkg.sv
// Shared types for the parametrised register file and its read ports.
package regfile_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux with busy / zero-register / bypass priority.
module regfile_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  rd_addr,
  input  logic                               busy,
  input  logic                               byp_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rd_data
);

  // byp_en already folds in the BYPASS parameter and write acceptance.
  always_comb begin
    rd_data = mem[rd_addr];
    if (busy) begin
      rd_data = '0;
    end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end else if (byp_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// DEPTH x DATA_W register file with NUM_RD read ports, one write port, optional
// write bypass and zero register, and a one-entry-per-cycle clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_t                   state;
  logic [ADDR_W-1:0]           clr_idx;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                        wr_fire;
  logic                        wr_keep;
  logic                        byp_en;

  assign clr_busy = (state == RF_CLEAR);
  assign wr_ready = !clr_busy;
  assign wr_fire  = wr_en && wr_ready;
  // A write to the hardwired zero entry is accepted but has no effect.
  assign wr_keep  = wr_fire && !((ZERO_REG != 0) && (wr_addr == '0));
  assign byp_en   = (BYPASS != 0) && wr_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RF_CLEAR;
      clr_idx  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
          end
        end
        RF_CLEAR: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state    <= RF_IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= RF_CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it, and writes are blocked meanwhile.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      mem[clr_idx] <= '0;
    end else if (wr_keep) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .mem     (mem),
      .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
      .busy    (clr_busy),
      .byp_en  (byp_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed table over three small configurations sharing
// stimulus, then randomized traffic on a 3-port, 8-entry instance against a model.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the three ADDR_W=2 / NUM_RD=2 instances.
  logic        rst, wr_en, clr_req;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr;

  logic [63:0] a_rd_data, b_rd_data, z_rd_data;
  logic        a_ready, a_busy, a_done;
  logic        b_ready, b_busy, b_done;
  logic        z_ready, z_busy, z_done;

  // Wide instance stimulus/outputs.
  logic        w_rst, w_wr_en, w_clr_req;
  logic [2:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [8:0]  w_rd_addr;
  logic [95:0] w_rd_data;
  logic        w_ready, w_busy, w_done;

  regfile_param #(.DATA_W(32), .ADDR_W(2), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(a_ready), .clr_req(clr_req),
    .clr_busy(a_busy), .clr_done(a_done));

  regfile_param #(.DATA_W(32), .ADDR_W(2), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(b_ready), .clr_req(clr_req),
    .clr_busy(b_busy), .clr_done(b_done));

  regfile_param #(.DATA_W(32), .ADDR_W(2), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(z_rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(z_ready), .clr_req(clr_req),
    .clr_busy(z_busy), .clr_done(z_done));

  regfile_param #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_w (
    .clk(clk), .rst(w_rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .wr_en(w_wr_en),
    .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_ready(w_ready), .clr_req(w_clr_req),
    .clr_busy(w_busy), .clr_done(w_done));

  typedef struct {
    bit          chk;
    bit          rst;
    bit          clr;
    bit          we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra0;
    logic [1:0]  ra1;
    bit          busy;
    bit          done;
    logic [31:0] a0, a1, b0, b1, z0, z1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit chk, input bit r, input bit c, input bit we,
                              input logic [1:0] wa, input logic [31:0] wd,
                              input logic [1:0] ra0, input logic [1:0] ra1,
                              input bit busy, input bit done,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] z0, input logic [31:0] z1);
    vec_t v;
    v.chk = chk; v.rst = r; v.clr = c; v.we = we; v.wa = wa; v.wd = wd;
    v.ra0 = ra0; v.ra1 = ra1; v.busy = busy; v.done = done;
    v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.z0 = z0; v.z1 = z1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    clr_req = v.clr;
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_data = v.wd;
    rd_addr = {v.ra1, v.ra0};
  endtask

  // Reference model of the wide instance: remaining sweep entries, done flag, contents.
  localparam int WDEPTH = 8;
  logic [31:0] wmem [WDEPTH];
  int          wleft;
  bit          wdone;

  function automatic logic [31:0] wExpect(input logic [2:0] ra);
    if (wleft > 0) return 32'h0;
    if (ra == 3'd0) return 32'h0;
    if (w_wr_en && (w_wr_addr == ra)) return w_wr_data;
    return wmem[ra];
  endfunction

  task automatic modelStep();
    bit busy_now;
    busy_now = (wleft > 0);
    if (!busy_now && w_wr_en && (w_wr_addr != 3'd0)) wmem[w_wr_addr] = w_wr_data;
    if (busy_now) begin
      wmem[WDEPTH - wleft] = 32'h0;
      wleft--;
      wdone = (wleft == 0);
    end else begin
      wdone = 1'b0;
    end
    if (w_rst) begin
      wleft = WDEPTH;
      wdone = 1'b0;
    end else if (!busy_now && w_clr_req) begin
      wleft = WDEPTH;
    end
  endtask

  initial begin
    vec_t v;
    logic [2:0] ra;

    w_rst = 1'b1; w_wr_en = 1'b0; w_clr_req = 1'b0;
    w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;

    //          chk rst clr we wa  wd            ra0 ra1 bsy dn  a0            a1        b0            b1        z0            z1
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 1, 3, 32'h55,       2, 1, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'hAAAA,     1, 2, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 1, 2, 32'hDEADBEEF, 2, 1, 0, 1, 32'hDEADBEEF, 0,        0,            0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h1234,     2, 0, 0, 0, 32'hDEADBEEF, 32'h1234, 32'hDEADBEEF, 0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h1234,     32'h1234, 32'h1234,     32'h1234, 0,            0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h1,        0, 3, 0, 0, 32'h1,        0,        32'h1234,     0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h2,        0, 1, 0, 0, 32'h1,        32'h2,    32'h1,        0,        0,            32'h2));
    vecs.push_back(mk(1, 0, 0, 1, 2, 32'h3,        2, 1, 0, 0, 32'h3,        32'h2,    32'hDEADBEEF, 32'h2,    32'h3,        32'h2));
    vecs.push_back(mk(1, 0, 0, 1, 3, 32'h4,        3, 2, 0, 0, 32'h4,        32'h3,    32'h0,        32'h3,    32'h4,        32'h3));
    vecs.push_back(mk(1, 0, 1, 1, 3, 32'h9,        3, 0, 0, 0, 32'h9,        32'h1,    32'h4,        32'h1,    32'h9,        32'h0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 32'h77,       1, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 32'h66,       0, 2, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        3, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        3, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 1, 0, 1, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        2, 3, 0, 0, 0,            0,        0,            0,        0,            0));
    // Reset mid-sweep: the sweep must restart and stay busy four more cycles.
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        2, 3, 0, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        2, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        2, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        2, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        2, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        2, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        2, 3, 1, 0, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        3, 0, 0, 1, 0,            0,        0,            0,        0,            0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        3, 0, 0, 0, 0,            0,        0,            0,        0,            0));

    $display("[TB] directed phase: %0d rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v);
      @(negedge clk);
      if (v.chk) begin
        checkOutput($sformatf("row%0d a_busy", i),  {31'h0, a_busy},  {31'h0, v.busy});
        checkOutput($sformatf("row%0d b_busy", i),  {31'h0, b_busy},  {31'h0, v.busy});
        checkOutput($sformatf("row%0d z_busy", i),  {31'h0, z_busy},  {31'h0, v.busy});
        checkOutput($sformatf("row%0d a_ready", i), {31'h0, a_ready}, {31'h0, !v.busy});
        checkOutput($sformatf("row%0d b_ready", i), {31'h0, b_ready}, {31'h0, !v.busy});
        checkOutput($sformatf("row%0d z_ready", i), {31'h0, z_ready}, {31'h0, !v.busy});
        checkOutput($sformatf("row%0d a_done", i),  {31'h0, a_done},  {31'h0, v.done});
        checkOutput($sformatf("row%0d b_done", i),  {31'h0, b_done},  {31'h0, v.done});
        checkOutput($sformatf("row%0d z_done", i),  {31'h0, z_done},  {31'h0, v.done});
        checkOutput($sformatf("row%0d a_rd0", i), a_rd_data[31:0],  v.a0);
        checkOutput($sformatf("row%0d a_rd1", i), a_rd_data[63:32], v.a1);
        checkOutput($sformatf("row%0d b_rd0", i), b_rd_data[31:0],  v.b0);
        checkOutput($sformatf("row%0d b_rd1", i), b_rd_data[63:32], v.b1);
        checkOutput($sformatf("row%0d z_rd0", i), z_rd_data[31:0],  v.z0);
        checkOutput($sformatf("row%0d z_rd1", i), z_rd_data[63:32], v.z1);
      end
      @(posedge clk);
      #1;
    end

    // Randomized phase on the wide instance (held in reset until now).
    for (int k = 0; k < WDEPTH; k++) wmem[k] = 32'h0;
    wleft = WDEPTH;
    wdone = 1'b0;
    $display("[TB] random phase: 1000 cycles");
    for (int cyc = 0; cyc < 1000; cyc++) begin
      w_rst     = (cyc == 0) || ($urandom_range(0, 63) == 0);
      w_clr_req = ($urandom_range(0, 31) == 0);
      w_wr_en   = $urandom_range(0, 1) == 1;
      w_wr_addr = 3'($urandom_range(0, 7));
      w_wr_data = $urandom;
      for (int p = 0; p < 3; p++) begin
        ra = 3'($urandom_range(0, 7));
        if (p == 0 && $urandom_range(0, 1) == 1) ra = w_wr_addr;
        w_rd_addr[p*3 +: 3] = ra;
      end
      @(negedge clk);
      checkOutput($sformatf("cyc%0d w_busy", cyc),  {31'h0, w_busy},  {31'h0, (wleft > 0)});
      checkOutput($sformatf("cyc%0d w_ready", cyc), {31'h0, w_ready}, {31'h0, (wleft == 0)});
      checkOutput($sformatf("cyc%0d w_done", cyc),  {31'h0, w_done},  {31'h0, wdone});
      for (int p = 0; p < 3; p++) begin
        checkOutput($sformatf("cyc%0d w_rd%0d", cyc, p), w_rd_data[p*32 +: 32],
                    wExpect(w_rd_addr[p*3 +: 3]));
      end
      @(posedge clk);
      modelStep();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
